optical_slot_scheduler: RTL and testbench

Time-slot scheduler that drives the 4x4 optical switch configuration port. It holds a programmable table of up to four port permutations and issues each one in turn on the switch's config/valid interface. After each grant it enforces an optical guard interval, then opens a transmission window for the slot. It sits between the host/control register block and the 4x4 switch-element decoder, and gives the datapath framers per-slot window and slot-ID indications.

---
 rtl/optical_slot_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_optical_slot_scheduler.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/optical_slot_scheduler.sv
// Time-slot scheduler for the 4x4 optical switch: issues programmed permutations in turn,
// waits for the grant, holds an optical guard interval, then opens the slot's TX window.
module optical_slot_scheduler #(
  parameter int unsigned P_GUARD_CYC = 16,
  parameter int unsigned P_SLOT_CYC  = 256,
  parameter int unsigned P_GRANT_TO  = 8,
  parameter logic [7:0]  P_RST_ENTRY = 8'h4E
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_enable,
  input  logic [1:0] i_slot_num,
  input  logic       i_sched_wr_en,
  input  logic [1:0] i_sched_wr_addr,
  input  logic [7:0] i_sched_wr_data,
  output logic       o_sched_wr_err,
  output logic [7:0] o_op_config,
  output logic       o_config_valid,
  input  logic [3:0] i_switch_grant,
  input  logic       i_grant_valid,
  output logic [3:0] o_switch_state,
  output logic [1:0] o_slot_id,
  output logic       o_guard,
  output logic       o_tx_window,
  output logic       o_grant_timeout
);

  localparam int unsigned MAX_GS  = (P_GUARD_CYC > P_SLOT_CYC) ? P_GUARD_CYC : P_SLOT_CYC;
  localparam int unsigned CNT_MAX = (MAX_GS > P_GRANT_TO) ? MAX_GS : P_GRANT_TO;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned N_ENTRY = 4;

  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(P_GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(P_SLOT_CYC - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(P_GRANT_TO - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_WAIT_GRANT,
    S_GUARD,
    S_TX
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       slot_q, slot_d;
  logic [1:0]       active_q, active_d;
  logic [7:0]       sched_tbl [N_ENTRY];

  logic [7:0]       op_cfg_d;
  logic             cfg_valid_d;
  logic [3:0]       sw_state_d;
  logic             guard_d;
  logic             tx_d;
  logic             timeout_d;
  logic             wr_legal_c;

  // Decoder-supported permutations: distinct fields, dst3 != 0, dst2 != 1 (14 codes)
  function automatic logic perm_legal(input logic [7:0] p);
    logic [1:0] f3, f2, f1, f0;
    f3 = p[7:6];
    f2 = p[5:4];
    f1 = p[3:2];
    f0 = p[1:0];
    return (f3 != f2) && (f3 != f1) && (f3 != f0) &&
           (f2 != f1) && (f2 != f0) && (f1 != f0) &&
           (f3 != 2'd0) && (f2 != 2'd1);
  endfunction

  assign wr_legal_c = perm_legal(i_sched_wr_data);

  // Schedule table; rejected writes leave the entry untouched and flag an error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < N_ENTRY; i++) sched_tbl[i] <= P_RST_ENTRY;
      o_sched_wr_err <= 1'b0;
    end else begin
      o_sched_wr_err <= i_sched_wr_en && !wr_legal_c;
      if (i_sched_wr_en && wr_legal_c) sched_tbl[i_sched_wr_addr] <= i_sched_wr_data;
    end
  end

  // State register and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q         <= S_IDLE;
      cnt_q           <= '0;
      slot_q          <= '0;
      active_q        <= '0;
      o_op_config     <= P_RST_ENTRY;
      o_config_valid  <= 1'b0;
      o_switch_state  <= '0;
      o_slot_id       <= '0;
      o_guard         <= 1'b0;
      o_tx_window     <= 1'b0;
      o_grant_timeout <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      slot_q          <= slot_d;
      active_q        <= active_d;
      o_op_config     <= op_cfg_d;
      o_config_valid  <= cfg_valid_d;
      o_switch_state  <= sw_state_d;
      o_slot_id       <= slot_d;
      o_guard         <= guard_d;
      o_tx_window     <= tx_d;
      o_grant_timeout <= timeout_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    active_d    = active_q;
    sw_state_d  = o_switch_state;
    timeout_d   = 1'b0;
    op_cfg_d    = o_op_config;
    cfg_valid_d = 1'b0;
    guard_d     = 1'b0;
    tx_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          state_d  = S_CFG;
          slot_d   = '0;
          active_d = i_slot_num;
        end
      end
      S_CFG: begin
        state_d = S_WAIT_GRANT;
        cnt_d   = '0;
      end
      S_WAIT_GRANT: begin
        // A grant in the same cycle as the timeout takes priority
        if (i_grant_valid) begin
          sw_state_d = i_switch_grant;
          state_d    = S_GUARD;
          cnt_d      = '0;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CFG;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_GUARD: begin
        if (cnt_q == GUARD_LAST) begin
          state_d = S_TX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TX: begin
        if (cnt_q == SLOT_LAST) begin
          cnt_d = '0;
          // Slot count changes are picked up only on wrap
          if (slot_q == active_q) begin
            slot_d   = '0;
            active_d = i_slot_num;
          end else begin
            slot_d = slot_q + 1'b1;
          end
          if (i_enable) begin
            state_d = S_CFG;
          end else begin
            state_d = S_IDLE;
            slot_d  = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        slot_d  = '0;
      end
    endcase

    cfg_valid_d = (state_d == S_CFG);
    guard_d     = (state_d == S_GUARD);
    tx_d        = (state_d == S_TX);
    if (state_d == S_CFG) op_cfg_d = sched_tbl[slot_d];
  end

endmodule

// File: tb/tb_optical_slot_scheduler.sv
// Directed bench for optical_slot_scheduler with a one-cycle-latency stub decoder
// whose grant is the low nibble of the issued permutation.
module tb_optical_slot_scheduler;

  localparam int unsigned G  = 4;
  localparam int unsigned S  = 8;
  localparam int unsigned TO = 8;

  logic       i_clk;
  logic       i_rst_n;
  logic       i_enable;
  logic [1:0] i_slot_num;
  logic       i_sched_wr_en;
  logic [1:0] i_sched_wr_addr;
  logic [7:0] i_sched_wr_data;
  logic       o_sched_wr_err;
  logic [7:0] o_op_config;
  logic       o_config_valid;
  logic [3:0] i_switch_grant;
  logic       i_grant_valid;
  logic [3:0] o_switch_state;
  logic [1:0] o_slot_id;
  logic       o_guard;
  logic       o_tx_window;
  logic       o_grant_timeout;

  logic       dec_silent = 1'b0;
  logic       dec_gv;
  logic [3:0] dec_grant;
  logic       cv_prev;
  logic       inj_gv = 1'b0;
  logic [3:0] inj_grant = 4'h0;

  int checks = 0;
  int errors = 0;
  int accepted;
  logic [7:0] exp_op [3];
  int slot_e;

  assign i_grant_valid  = dec_gv | inj_gv;
  assign i_switch_grant = inj_gv ? inj_grant : dec_grant;

  optical_slot_scheduler #(
    .P_GUARD_CYC(G),
    .P_SLOT_CYC (S),
    .P_GRANT_TO (TO),
    .P_RST_ENTRY(8'h4E)
  ) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_slot_num     (i_slot_num),
    .i_sched_wr_en  (i_sched_wr_en),
    .i_sched_wr_addr(i_sched_wr_addr),
    .i_sched_wr_data(i_sched_wr_data),
    .o_sched_wr_err (o_sched_wr_err),
    .o_op_config    (o_op_config),
    .o_config_valid (o_config_valid),
    .i_switch_grant (i_switch_grant),
    .i_grant_valid  (i_grant_valid),
    .o_switch_state (o_switch_state),
    .o_slot_id      (o_slot_id),
    .o_guard        (o_guard),
    .o_tx_window    (o_tx_window),
    .o_grant_timeout(o_grant_timeout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Stub decoder: grant one cycle after the config strobe
  initial begin
    dec_gv    = 1'b0;
    dec_grant = 4'h0;
    cv_prev   = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      dec_gv    = cv_prev && !dec_silent;
      dec_grant = o_op_config[3:0];
      cv_prev   = o_config_valid;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    i_rst_n         = 1'b0;
    i_enable        = 1'b0;
    i_slot_num      = 2'd0;
    i_sched_wr_en   = 1'b0;
    i_sched_wr_addr = 2'd0;
    i_sched_wr_data = 8'h00;

    // Reset defaults
    #23;
    check("rst_op_config", 32'(o_op_config), 32'h4E);
    check("rst_cfg_valid", 32'(o_config_valid), 32'd0);
    check("rst_tx", 32'(o_tx_window), 32'd0);
    i_rst_n = 1'b1;
    tick(1);
    check("idle_op_config", 32'(o_op_config), 32'h4E);
    check("idle_outputs", 32'({o_sched_wr_err, o_config_valid, o_switch_state, o_slot_id,
                               o_guard, o_tx_window, o_grant_timeout}), 32'd0);

    // Single-slot schedule from reset table
    i_slot_num = 2'd0;
    i_enable   = 1'b1;
    tick(1);
    check("one_slot_cfg0", 32'(o_config_valid), 32'd1);
    check("one_slot_op0", 32'(o_op_config), 32'h4E);
    tick(14);
    check("one_slot_cfg1", 32'(o_config_valid), 32'd1);
    check("one_slot_id1", 32'(o_slot_id), 32'd0);
    check("one_slot_op1", 32'(o_op_config), 32'h4E);
    check("one_slot_sw", 32'(o_switch_state), 32'hE);
    i_enable = 1'b0;
    tick(13);
    check("one_slot_last_tx", 32'(o_tx_window), 32'd1);
    tick(1);
    check("one_slot_idle", 32'({o_config_valid, o_tx_window, o_guard}), 32'd0);

    // Table write legality
    i_sched_wr_en   = 1'b1;
    i_sched_wr_addr = 2'd1;
    i_sched_wr_data = 8'hE4;
    tick(1);
    check("wr_E4_ok", 32'(o_sched_wr_err), 32'd0);
    i_sched_wr_data = 8'h1B;
    tick(1);
    check("wr_1B_err", 32'(o_sched_wr_err), 32'd1);
    i_sched_wr_data = 8'h93;
    tick(1);
    check("wr_93_err", 32'(o_sched_wr_err), 32'd1);
    i_sched_wr_addr = 2'd2;
    i_sched_wr_data = 8'h9C;
    tick(1);
    check("wr_9C_err", 32'(o_sched_wr_err), 32'd1);
    i_sched_wr_data = 8'h78;
    tick(1);
    check("wr_78_ok", 32'(o_sched_wr_err), 32'd0);
    i_sched_wr_en = 1'b0;
    tick(1);
    check("wr_err_clear", 32'(o_sched_wr_err), 32'd0);

    // Sweep all codes into entry 3
    accepted        = 0;
    i_sched_wr_en   = 1'b1;
    i_sched_wr_addr = 2'd3;
    for (int c = 0; c < 256; c++) begin
      i_sched_wr_data = 8'(c);
      tick(1);
      if (!o_sched_wr_err) accepted++;
    end
    i_sched_wr_en = 1'b0;
    check("sweep_legal_count", 32'(accepted), 32'd14);

    // Three-slot rotation: 4E / E4 / 78
    exp_op[0]  = 8'h4E;
    exp_op[1]  = 8'hE4;
    exp_op[2]  = 8'h78;
    i_slot_num = 2'd2;
    i_enable   = 1'b1;
    tick(1);
    for (int k = 0; k < 4; k++) begin
      slot_e = k % 3;
      check("rot_cfg", 32'(o_config_valid), 32'd1);
      check("rot_slot", 32'(o_slot_id), 32'(slot_e));
      check("rot_op", 32'(o_op_config), 32'(exp_op[slot_e]));
      tick(1);
      check("rot_wait", 32'({o_config_valid, o_guard, o_tx_window}), 32'd0);
      tick(1);
      check("rot_guard_first", 32'(o_guard), 32'd1);
      check("rot_sw", 32'(o_switch_state), 32'(exp_op[slot_e][3:0]));
      tick(3);
      check("rot_guard_last", 32'({o_guard, o_tx_window}), 32'b10);
      tick(1);
      check("rot_tx_first", 32'({o_guard, o_tx_window}), 32'b01);
      tick(7);
      check("rot_tx_last", 32'(o_tx_window), 32'd1);
      tick(1);
    end

    // Disable during guard of slot 1: slot completes, then idle
    check("dis_slot1", 32'(o_slot_id), 32'd1);
    tick(2);
    check("dis_guard", 32'(o_guard), 32'd1);
    i_enable = 1'b0;
    tick(4);
    check("dis_tx_first", 32'(o_tx_window), 32'd1);
    tick(7);
    check("dis_tx_last", 32'(o_tx_window), 32'd1);
    tick(1);
    check("dis_idle", 32'({o_config_valid, o_tx_window, o_slot_id}), 32'd0);
    tick(1);
    check("dis_idle_hold", 32'(o_config_valid), 32'd0);
    i_enable = 1'b1;
    tick(1);
    check("reen_cfg", 32'(o_config_valid), 32'd1);
    check("reen_slot", 32'(o_slot_id), 32'd0);
    check("reen_op", 32'(o_op_config), 32'h4E);

    // Grant timeout with silent decoder, then retry of the same slot
    dec_silent = 1'b1;
    tick(8);
    check("to_waiting", 32'({o_grant_timeout, o_config_valid, o_tx_window}), 32'd0);
    tick(1);
    check("to_pulse", 32'(o_grant_timeout), 32'd1);
    check("to_retry_cfg", 32'(o_config_valid), 32'd1);
    check("to_retry_slot", 32'(o_slot_id), 32'd0);
    check("to_no_tx", 32'(o_tx_window), 32'd0);
    dec_silent = 1'b0;
    tick(1);
    check("to_pulse_end", 32'(o_grant_timeout), 32'd0);
    tick(1);
    check("retry_guard", 32'(o_guard), 32'd1);
    check("retry_sw", 32'(o_switch_state), 32'hE);

    // Stray grant during guard is ignored
    inj_grant = 4'h5;
    inj_gv    = 1'b1;
    tick(1);
    inj_gv = 1'b0;
    check("stray_sw", 32'(o_switch_state), 32'hE);
    check("stray_guard", 32'(o_guard), 32'd1);
    tick(3);
    check("pre_rst_tx", 32'(o_tx_window), 32'd1);

    // Asynchronous reset in TX
    #3;
    i_rst_n = 1'b0;
    #1;
    check("arst_tx", 32'(o_tx_window), 32'd0);
    check("arst_op", 32'(o_op_config), 32'h4E);
    check("arst_slot", 32'(o_slot_id), 32'd0);
    #3;
    i_rst_n = 1'b1;
    tick(1);
    check("post_rst_cfg", 32'(o_config_valid), 32'd1);
    check("post_rst_op0", 32'(o_op_config), 32'h4E);
    tick(14);
    check("post_rst_slot1", 32'(o_slot_id), 32'd1);
    check("post_rst_op1", 32'(o_op_config), 32'h4E);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
